// File: rtl/vec_pkg.sv
// Shared constants and encodings for the vector coalescing stage.
// Kind codes match the in_kind field driven by the exec lanes.
package vec_pkg;

    localparam int LANES     = 4;
    localparam int ELEM_W    = 16;
    localparam int MAX_ELEMS = 16;

    typedef enum logic [1:0] {
        KIND_SCALAR = 2'd0,
        KIND_VECTOR = 2'd1,
        KIND_DOT    = 2'd2,
        KIND_RSVD   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

endpackage

// File: rtl/lane_sum4.sv
// Masked sum of the four lane results, wrapping modulo 2^ELEM_W.
// Lanes whose valid bit is clear contribute zero to the sum.
module lane_sum4
    import vec_pkg::*;
(
    input  logic [LANES*ELEM_W-1:0] lane_data_i,
    input  logic [LANES-1:0]        lane_valid_i,
    output logic [ELEM_W-1:0]       sum_o
);

    logic [LANES-1:0][ELEM_W-1:0] laneVals;

    assign laneVals = lane_data_i;

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid_i[i]) begin
                sum_o = sum_o + laneVals[2'(i)];
            end
        end
    end

endmodule

// File: rtl/vector_coalesce.sv
// Gathers per-beat lane results of one instruction into a single writeback
// record (vector+mask, scalar, or dot sum) and hands it over valid/ready.
module vector_coalesce
    import vec_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [1:0]                  in_beat,
    input  logic [1:0]                  in_kind,
    input  logic [3:0]                  in_rt,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES*ELEM_W-1:0]     in_lane_data,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic                        wb_is_vector,
    output logic [3:0]                  wb_rt,
    output logic [ELEM_W-1:0]           wb_scalar,
    output logic [MAX_ELEMS*ELEM_W-1:0] wb_vector,
    output logic [MAX_ELEMS-1:0]        wb_mask,
    output logic                        err
);

    state_e                           state_q;
    kind_e                            kind_q;
    logic [3:0]                       rt_q;
    logic                             isVec_q;
    logic                             wbValid_q;
    logic                             err_q;
    logic [MAX_ELEMS-1:0][ELEM_W-1:0] vec_q,    vec_d;
    logic [MAX_ELEMS-1:0]             mask_q,   mask_d;
    logic [ELEM_W-1:0]                scalar_q, scalar_d;

    logic [LANES-1:0][ELEM_W-1:0]     laneVals;
    logic [ELEM_W-1:0]                laneSum;
    kind_e                            effKind;
    logic                             accept;
    logic                             absorb;
    logic                             beatErr;

    assign laneVals = in_lane_data;
    assign accept   = in_valid && in_ready;
    // In IDLE only a first beat may start a record; in COLLECT every beat lands.
    assign absorb   = accept && (in_first || (state_q == COLLECT));

    lane_sum4 u_lane_sum4 (
        .lane_data_i  (in_lane_data),
        .lane_valid_i (in_lane_valid),
        .sum_o        (laneSum)
    );

    // A first beat starts from a cleared record and its own kind; later beats build on the latched one.
    always_comb begin
        effKind  = in_first ? kind_e'(in_kind) : kind_q;
        vec_d    = in_first ? '0 : vec_q;
        mask_d   = in_first ? '0 : mask_q;
        scalar_d = in_first ? '0 : scalar_q;
        beatErr  = 1'b0;
        case (effKind)
            KIND_VECTOR: begin
                for (int i = 0; i < LANES; i++) begin
                    if (in_lane_valid[i]) begin
                        vec_d[{in_beat, 2'(i)}]  = laneVals[2'(i)];
                        mask_d[{in_beat, 2'(i)}] = 1'b1;
                    end
                end
            end
            KIND_SCALAR: begin
                if (in_lane_valid[0]) begin
                    scalar_d = laneVals[0];
                end
                beatErr = !in_last;
            end
            KIND_DOT: begin
                scalar_d = scalar_d + laneSum;
            end
            default: begin
                beatErr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            kind_q    <= KIND_SCALAR;
            rt_q      <= '0;
            isVec_q   <= 1'b0;
            wbValid_q <= 1'b0;
            err_q     <= 1'b0;
            vec_q     <= '0;
            mask_q    <= '0;
            scalar_q  <= '0;
        end else begin
            if (absorb) begin
                vec_q    <= vec_d;
                mask_q   <= mask_d;
                scalar_q <= scalar_d;
                if (in_first) begin
                    kind_q  <= kind_e'(in_kind);
                    rt_q    <= in_rt;
                    isVec_q <= (kind_e'(in_kind) == KIND_VECTOR);
                end
                if (beatErr) begin
                    err_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (state_q == IDLE && !in_first) begin
                            err_q <= 1'b1;
                        end else begin
                            if (state_q == COLLECT && in_first) begin
                                err_q <= 1'b1;
                            end
                            state_q   <= in_last ? OUTPUT : COLLECT;
                            wbValid_q <= in_last;
                        end
                    end
                end
                OUTPUT: begin
                    if (wb_ready) begin
                        state_q   <= IDLE;
                        wbValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    wbValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = !rst && (state_q != OUTPUT);
    assign wb_valid     = wbValid_q;
    assign wb_is_vector = isVec_q;
    assign wb_rt        = rt_q;
    assign wb_scalar    = scalar_q;
    assign wb_vector    = vec_q;
    assign wb_mask      = mask_q;
    assign err          = err_q;

endmodule

// File: tb/tb_vector_coalesce.sv
// Scoreboard bench for vector_coalesce: expected records are queued as
// stimulus is issued and checked when writeback handshakes them out.
module tb_vector_coalesce;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic         in_last;
    logic [1:0]   in_beat;
    logic [1:0]   in_kind;
    logic [3:0]   in_rt;
    logic [3:0]   in_lane_valid;
    logic [63:0]  in_lane_data;
    logic         wb_valid;
    logic         wb_ready;
    logic         wb_is_vector;
    logic [3:0]   wb_rt;
    logic [15:0]  wb_scalar;
    logic [255:0] wb_vector;
    logic [15:0]  wb_mask;
    logic         err;

    typedef struct {
        logic         isVec;
        logic [3:0]   rt;
        logic [15:0]  scalar;
        logic [255:0] vector;
        logic [15:0]  mask;
    } expRec_t;

    expRec_t expQ[$];
    expRec_t monRec;
    int      assertCount = 0;
    int      failCount   = 0;

    vector_coalesce dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_first      (in_first),
        .in_last       (in_last),
        .in_beat       (in_beat),
        .in_kind       (in_kind),
        .in_rt         (in_rt),
        .in_lane_valid (in_lane_valid),
        .in_lane_data  (in_lane_data),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_is_vector  (wb_is_vector),
        .wb_rt         (wb_rt),
        .wb_scalar     (wb_scalar),
        .wb_vector     (wb_vector),
        .wb_mask       (wb_mask),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one beat and returns just after the clock edge that accepts it.
    task automatic applyStimulus(input logic first, input logic last, input logic [1:0] beat,
                                 input logic [1:0] kind, input logic [3:0] rt,
                                 input logic [3:0] laneValid, input logic [63:0] data);
        bit accepted = 0;
        in_valid      = 1'b1;
        in_first      = first;
        in_last       = last;
        in_beat       = beat;
        in_kind       = kind;
        in_rt         = rt;
        in_lane_valid = laneValid;
        in_lane_data  = data;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                accepted = 1;
            end
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic waitRetire();
        for (int c = 0; c < 10; c++) begin
            if (!wb_valid && expQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("retired", {255'b0, (!wb_valid && expQ.size() == 0)}, 1);
    endtask

    task automatic pushExp(input logic isVec, input logic [3:0] rt, input logic [15:0] scalar,
                           input logic [255:0] vector, input logic [15:0] mask);
        expRec_t r;
        r.isVec  = isVec;
        r.rt     = rt;
        r.scalar = scalar;
        r.vector = vector;
        r.mask   = mask;
        expQ.push_back(r);
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRecord", 1, 0);
            end else begin
                monRec = expQ.pop_front();
                checkOutput("wbIsVector", wb_is_vector, monRec.isVec);
                checkOutput("wbRt", wb_rt, monRec.rt);
                checkOutput("wbMask", wb_mask, monRec.mask);
                if (monRec.isVec) checkOutput("wbVector", wb_vector, monRec.vector);
                else              checkOutput("wbScalar", wb_scalar, monRec.scalar);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0][15:0] ev;
        int validSeen;

        rst = 1'b1;  in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_beat = '0; in_kind = '0; in_rt = '0; in_lane_valid = '0;
        in_lane_data = '0; wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetWbValid", wb_valid, 0);
        checkOutput("resetErr", err, 0);
        checkOutput("resetVector", wb_vector, 0);
        checkOutput("resetMask", wb_mask, 0);
        checkOutput("resetScalar", wb_scalar, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idleInReady", in_ready, 1);

        $display("[TB] scalar op");
        pushExp(0, 4'd3, 16'h1234, '0, 16'h0000);
        applyStimulus(1, 1, 2'd0, 2'd0, 4'd3, 4'b0001, 64'hDEAD_BEEF_CAFE_1234);
        checkOutput("scalarLatency", wb_valid, 1);
        waitRetire();

        $display("[TB] full vector");
        for (int k = 0; k < 16; k++) ev[k] = 16'(k);
        pushExp(1, 4'd5, 16'h0, ev, 16'hFFFF);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(b == 0, b == 3, 2'(b), 2'd1, 4'd5, 4'b1111,
                          {16'(4*b+3), 16'(4*b+2), 16'(4*b+1), 16'(4*b)});
            if (b < 3) checkOutput("vecNotYetValid", wb_valid, 0);
        end
        checkOutput("vecLatency", wb_valid, 1);
        waitRetire();

        $display("[TB] partial vector");
        ev = '0;
        ev[0] = 16'hA0; ev[1] = 16'hA1; ev[2] = 16'hA2;
        ev[3] = 16'hA3; ev[4] = 16'hA4; ev[5] = 16'hA5;
        pushExp(1, 4'd7, 16'h0, ev, 16'h003F);
        applyStimulus(1, 0, 2'd0, 2'd1, 4'd7, 4'b1111, 64'h00A3_00A2_00A1_00A0);
        applyStimulus(0, 1, 2'd1, 2'd1, 4'd7, 4'b0011, 64'hFFFF_FFFF_00A5_00A4);
        waitRetire();

        $display("[TB] dot products");
        pushExp(0, 4'd1, 16'h0000, '0, 16'h0000);
        applyStimulus(1, 0, 2'd0, 2'd2, 4'd1, 4'b1111, 64'h8000_8000_8000_8000);
        applyStimulus(0, 1, 2'd1, 2'd2, 4'd1, 4'b1111, 64'h8000_8000_8000_8000);
        waitRetire();
        pushExp(0, 4'd1, 16'h000A, '0, 16'h0000);
        applyStimulus(1, 1, 2'd0, 2'd2, 4'd1, 4'b1111, 64'h0004_0003_0002_0001);
        checkOutput("dotLatency", wb_valid, 1);
        waitRetire();

        $display("[TB] backpressure");
        wb_ready = 1'b0;
        ev = '0;
        ev[9] = 16'hAAAA; ev[11] = 16'hBBBB;
        pushExp(1, 4'd9, 16'h0, ev, 16'h0A00);
        applyStimulus(1, 1, 2'd2, 2'd1, 4'd9, 4'b1010, 64'hBBBB_1111_AAAA_2222);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bpValid", wb_valid, 1);
            checkOutput("bpInReady", in_ready, 0);
            checkOutput("bpMask", wb_mask, 16'h0A00);
            checkOutput("bpVector", wb_vector, ev);
            checkOutput("bpRt", wb_rt, 4'd9);
            @(posedge clk);
            #1;
        end
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpRetireInReady", in_ready, 1);
        checkOutput("bpRetireValid", wb_valid, 0);
        checkOutput("noErrYet", err, 0);

        $display("[TB] first beat during collect");
        pushExp(0, 4'd4, 16'h0042, '0, 16'h0000);
        applyStimulus(1, 0, 2'd0, 2'd1, 4'd2, 4'b1111, 64'h1111_2222_3333_4444);
        applyStimulus(1, 1, 2'd0, 2'd0, 4'd4, 4'b0001, 64'h0000_0000_0000_0042);
        checkOutput("restartErr", err, 1);
        checkOutput("restartLatency", wb_valid, 1);
        waitRetire();

        $display("[TB] last-only beat in idle");
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("errClearedByReset", err, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1, 2'd0, 2'd1, 4'd8, 4'b1111, 64'h5555_6666_7777_8888);
        checkOutput("dropErr", err, 1);
        checkOutput("dropNoValid", wb_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("dropStillIdle", in_ready, 1);

        $display("[TB] reset mid-collect");
        applyStimulus(1, 0, 2'd0, 2'd1, 4'd12, 4'b1111, 64'h0102_0304_0506_0708);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", wb_valid, 0);
        checkOutput("asyncRstMask", wb_mask, 0);
        checkOutput("asyncRstVector", wb_vector, 0);
        checkOutput("asyncRstRt", wb_rt, 0);
        checkOutput("asyncRstErr", err, 0);
        @(negedge clk);
        rst = 1'b0;
        validSeen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (wb_valid) validSeen++;
        end
        checkOutput("noValidAfterRst", validSeen, 0);

        $display("[TB] reserved kind");
        pushExp(0, 4'd6, 16'h0000, '0, 16'h0000);
        applyStimulus(1, 1, 2'd0, 2'd3, 4'd6, 4'b1111, 64'h9999_8888_7777_6666);
        checkOutput("rsvdErr", err, 1);
        checkOutput("rsvdLatency", wb_valid, 1);
        waitRetire();

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
